// File: rtl/serial_add_sequencer.sv
// Bit-serial adder sequencer. It streams two WIDTH-bit operands LSB-first through an
// external 1-bit full adder, then collects the sum bits and the final carry.
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_carry_in,
   input  logic             fa_c,
   input  logic             fa_carry_out
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_nx_s;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] result_r;
   logic [WIDTH-1:0] result_nx_s;
   logic             carry_q_r;
   logic             cout_r;
   logic             done_r;
   logic [CNT_W-1:0] cnt_r;
   logic             load_s;
   logic             shift_s;
   logic             last_s;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode and datapath strobes
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      shift_s    = 1'b0;
      last_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               load_s     = 1'b1;
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            shift_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
               last_s     = 1'b1;
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_DONE: begin
            state_nx_s = ST_IDLE;
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // New sum bit enters at the MSB, so after WIDTH shifts bit 0 holds the first sum bit
   always_comb begin
      result_nx_s = (result_r >> 1) | (WIDTH'(fa_c) << (WIDTH - 1));
   end

   // Operand shifters, carry, bit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa_r      <= '0;
         sb_r      <= '0;
         carry_q_r <= 1'b0;
         cnt_r     <= '0;
         result_r  <= '0;
         cout_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         if (load_s) begin
            sa_r      <= op_a;
            sb_r      <= op_b;
            carry_q_r <= cin;
            cnt_r     <= '0;
         end else if (shift_s) begin
            sa_r      <= sa_r >> 1;
            sb_r      <= sb_r >> 1;
            carry_q_r <= fa_carry_out;
            cnt_r     <= cnt_r + CNT_W'(1);
            result_r  <= result_nx_s;
            if (last_s) begin
               cout_r <= fa_carry_out;
            end else begin
               cout_r <= cout_r;
            end
         end else begin
            sa_r      <= sa_r;
            sb_r      <= sb_r;
            carry_q_r <= carry_q_r;
            cnt_r     <= cnt_r;
         end
         done_r <= last_s;
      end
   end

   // Full-adder drives are only live in RUN so the macro sees quiet inputs otherwise
   always_comb begin
      if (state_r == ST_RUN) begin
         fa_a        = sa_r[0];
         fa_b        = sb_r[0];
         fa_carry_in = carry_q_r;
      end else begin
         fa_a        = 1'b0;
         fa_b        = 1'b0;
         fa_carry_in = 1'b0;
      end
   end

   // Status and result outputs, all taken straight from registers
   always_comb begin
      busy   = (state_r != ST_IDLE);
      done   = done_r;
      result = result_r;
      cout   = cout_r;
   end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=8). A behavioural full adder sits
// on the fa_* ports, and expected sums are queued on start and popped on done.
module tb_serial_add_sequencer;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [WIDTH-1:0] op_a = '0;
   logic [WIDTH-1:0] op_b = '0;
   logic             cin = 1'b0;
   logic             busy, done, cout;
   logic [WIDTH-1:0] result;
   logic             fa_a, fa_b, fa_carry_in, fa_c, fa_carry_out;

   int               tests_run = 0;
   int               tests_failed = 0;
   logic [WIDTH:0]   exp_q[$];

   serial_add_sequencer #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
      .busy(busy), .done(done), .result(result), .cout(cout),
      .fa_a(fa_a), .fa_b(fa_b), .fa_carry_in(fa_carry_in),
      .fa_c(fa_c), .fa_carry_out(fa_carry_out)
   );

   // 1-bit full adder standing in for the openlane_full_adder macro
   assign fa_c         = fa_a ^ fa_b ^ fa_carry_in;
   assign fa_carry_out = (fa_a & fa_b) | (fa_carry_in & (fa_a ^ fa_b));

   always #5 clk = ~clk;

   task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic c, input bit expect_result);
      op_a  = a;
      op_b  = b;
      cin   = c;
      start = 1'b1;
      if (expect_result)
         exp_q.push_back((WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(c));
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      tests_run++;
      if ({busy, done, result, cout, fa_a, fa_b, fa_carry_in} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got busy=%b done=%b result=%h cout=%b fa=%b%b%b, expected all 0",
                  busy, done, result, cout, fa_a, fa_b, fa_carry_in);
      end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release_idle: got busy=%b done=%b, expected 0 0", busy, done);
      end
   endtask

   task automatic test_arith();
      logic [WIDTH-1:0] va[4] = '{8'h5A, 8'hFF, 8'hFF, 8'h00};
      logic [WIDTH-1:0] vb[4] = '{8'h33, 8'h01, 8'hFF, 8'h00};
      logic             vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [WIDTH:0]   want[4] = '{9'h08D, 9'h100, 9'h1FF, 9'h000};
      logic [WIDTH:0]   exp_v;
      int               edges;
      bit               got;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive_start(va[i], vb[i], vc[i], 1'b1);
         @(negedge clk);
         start = 1'b0;
         tests_run++;
         if (busy !== 1'b1 || fa_a !== va[i][0] || fa_b !== vb[i][0] || fa_carry_in !== vc[i]) begin
            tests_failed++;
            $display("FAIL arith_first_bit[%0d]: got busy=%b fa=%b%b%b, expected 1 %b%b%b",
                     i, busy, fa_a, fa_b, fa_carry_in, va[i][0], vb[i][0], vc[i]);
         end
         edges = 0;
         got   = 1'b0;
         while (!got && edges < 20) begin
            @(negedge clk);
            edges++;
            if (done === 1'b1) got = 1'b1;
         end
         tests_run++;
         if (!got || edges != WIDTH) begin
            tests_failed++;
            $display("FAIL arith_latency[%0d]: got done=%b after %0d edges, expected done after %0d",
                     i, got, edges, WIDTH);
         end
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         tests_run++;
         if ({cout, result} !== exp_v || {cout, result} !== want[i]) begin
            tests_failed++;
            $display("FAIL arith_sum[%0d]: got cout=%b result=%h, expected %h", i, cout, result, want[i]);
         end
         tests_run++;
         if ({fa_a, fa_b, fa_carry_in} !== 3'b000) begin
            tests_failed++;
            $display("FAIL arith_fa_quiet[%0d]: got fa=%b%b%b, expected 000", i, fa_a, fa_b, fa_carry_in);
         end
         @(negedge clk);
         tests_run++;
         if (done !== 1'b0 || busy !== 1'b0 || {cout, result} !== want[i]) begin
            tests_failed++;
            $display("FAIL arith_pulse_hold[%0d]: got done=%b busy=%b sum=%h, expected 0 0 %h",
                     i, done, busy, {cout, result}, want[i]);
         end
      end
   endtask

   task automatic test_start_ignored();
      int             pulses = 0;
      logic [WIDTH:0] seen = '0;
      logic [WIDTH:0] exp_v;
      @(negedge clk);
      drive_start(8'h12, 8'h34, 1'b0, 1'b1);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      drive_start(8'hAA, 8'h77, 1'b1, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (16) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            seen = {cout, result};
         end
      end
      tests_run++;
      if (pulses != 1) begin
         tests_failed++;
         $display("FAIL ignored_pulse_count: got %0d done pulses, expected 1", pulses);
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      tests_run++;
      if (seen !== exp_v) begin
         tests_failed++;
         $display("FAIL ignored_sum: got %h, expected %h", seen, exp_v);
      end
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL ignored_not_queued: got busy=%b, expected 0", busy);
      end
   endtask

   task automatic test_reset_abort();
      int             dones = 0;
      int             edges;
      bit             got;
      logic [WIDTH:0] exp_v;
      @(negedge clk);
      drive_start(8'hC3, 8'h5E, 1'b1, 1'b0);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if ({busy, done, result, cout, fa_a, fa_b, fa_carry_in} !== '0) begin
         tests_failed++;
         $display("FAIL abort_outputs: got busy=%b done=%b result=%h cout=%b fa=%b%b%b, expected all 0",
                  busy, done, result, cout, fa_a, fa_b, fa_carry_in);
      end
      repeat (4) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done === 1'b1) dones++;
      end
      tests_run++;
      if (dones != 0 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_no_done: got %0d done pulses busy=%b, expected 0 0", dones, busy);
      end
      drive_start(8'h7B, 8'h2C, 1'b1, 1'b1);
      @(negedge clk);
      start = 1'b0;
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 20) begin
         @(negedge clk);
         edges++;
         if (done === 1'b1) got = 1'b1;
      end
      exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      tests_run++;
      if (!got || {cout, result} !== exp_v || exp_v !== 9'h0A8) begin
         tests_failed++;
         $display("FAIL abort_fresh_add: got done=%b sum=%h, expected done=1 sum=0a8", got, {cout, result});
      end
   endtask

   task automatic test_back_to_back();
      localparam int NVEC = 1000;
      int             edges;
      bit             got;
      logic [WIDTH:0] exp_v;
      int             bad = 0;
      @(negedge clk);
      drive_start(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
      @(negedge clk);
      tests_run++;
      if (busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL b2b_first_accept: got busy=%b, expected 1", busy);
      end
      for (int i = 0; i < NVEC; i++) begin
         edges = 0;
         got   = 1'b0;
         while (!got && edges < 20) begin
            @(negedge clk);
            edges++;
            if (done === 1'b1) got = 1'b1;
         end
         exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         tests_run++;
         if (!got || edges != WIDTH || {cout, result} !== exp_v) begin
            tests_failed++;
            bad++;
            if (bad <= 10)
               $display("FAIL b2b_sum[%0d]: got done=%b edges=%0d sum=%h, expected done after %0d sum=%h",
                        i, got, edges, {cout, result}, WIDTH, exp_v);
         end
         if (i < NVEC - 1)
            drive_start(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b1);
         else
            start = 1'b0;
         @(negedge clk);
         tests_run++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_idle_gap[%0d]: got busy=%b done=%b, expected 0 0", i, busy, done);
         end
         if (i < NVEC - 1) begin
            @(negedge clk);
            tests_run++;
            if (busy !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_accept[%0d]: got busy=%b, expected 1", i, busy);
            end
         end
      end
      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL b2b_queue_drain: got %0d leftover results, expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
